board_move_collector: RTL
=========================

# board_move_collector

Board-level move gatherer sitting directly downstream of the eight column units. It arbitrates round-robin over the eight column move FIFOs and pops one move at a time. It drops moves flagged invalid and presents surviving moves on a single valid/ready stream to the move-list writer. It raises `done` once every column has finished and all column FIFOs are drained.

## Interface
Parameters:
- `NCOL`, 8, number of column units; fixed at 8 for this design.
- `MW`, 19, move word width: [18:12] flags [invalid, promote, pawn move, pawn 2 sq, en passant, castle, capture], [11:6] from, [5:0] to.
- `CW`, 8, width of the move and drop counters.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a collection pass.
- `col_done`  in  8  done flag per column; bit c = column c.
- `col_empty`  in  8  FIFO empty flag per column.
- `col_data`  in  152  FIFO read data; column c occupies [19c+18:19c]. Valid the cycle after `col_rden[c]`.
- `col_rden`  out  8  registered, one-hot read enable, one cycle wide.
- `out_move`  out  19  move word presented downstream.
- `out_valid`  out  1  `out_move` is valid.
- `out_ready`  in  1  downstream accepts; a transfer occurs when `out_valid` and `out_ready` are both high.
- `move_count`  out  8  number of moves transferred this pass; saturates at 255.
- `drop_count`  out  8  number of invalid-flagged moves discarded this pass; saturates at 255.
- `busy`  out  1  high in any state other than IDLE and DONE.
- `done`  out  1  high in the DONE state.

## Operation
States (one-hot or encoded, implementer's choice): IDLE, SCAN, READ, CAPT, OUT, DONE.
- **IDLE:** waits. `start` clears both counters, sets `rr_ptr`=7, then goes to SCAN.
- **SCAN:** eligible columns are those with `col_empty[c]`=0. The search order is `rr_ptr`+1, `rr_ptr`+2, … , `rr_ptr`, wrapping mod 8.
  - If a column is eligible: the first one found becomes `sel`, `rr_ptr` is set to `sel`, `col_rden[sel]` is registered high, and the state goes to READ.
  - Else if `&col_done`: go to DONE.
  - Else: stay in SCAN.
- **READ:** `col_rden` is high for exactly this cycle. Go to CAPT.
- **CAPT:** sample slice `sel` of `col_data`.
  - If bit 18 (invalid) is set: increment `drop_count` and return to SCAN.
  - Otherwise: load `out_move` and go to OUT.
- **OUT:** `out_valid`=1 and `out_move` is held stable. On `out_ready`: increment `move_count` and go to SCAN.
- **DONE:** `done`=1 and the counters are held. `start` restarts the pass: counters clear and the state goes to SCAN.

Rules:
- `start` is ignored in SCAN, READ, CAPT and OUT.
- Only one read is ever outstanding. A column's `col_empty` is next consulted at least 2 cycles after its `col_rden`, which covers the FIFO flag update latency.
- Counters saturate at 255; they never wrap.
- `col_done` high with `col_empty` low: the column is still drained. DONE requires both all `col_done` high and all `col_empty` high, sampled in SCAN.

## Timing
- All outputs are registered.
- Reset values: `col_rden`=0, `out_move`=0, `out_valid`=0, `move_count`=0, `drop_count`=0, `busy`=0, `done`=0, state=IDLE, `rr_ptr`=7.
- Reset is asynchronous: asserting `reset_n` mid-pass forces every output to its reset value immediately, including dropping `col_rden`. Any in-flight move is lost.
- Latency, with SCAN selection at cycle t:
  - `col_rden` high at t+1.
  - data captured at the t+2 edge.
  - `out_valid` high at t+3.
- With `out_ready` tied high, sustained throughput is 1 move per 4 cycles.
- An invalid move costs 3 cycles (SCAN, READ, CAPT) and produces no `out_valid`.
- `out_ready` low holds OUT indefinitely. No further `col_rden` is issued while in OUT.
- `start` to `busy`: `busy` rises the cycle after `start` is sampled in IDLE.
- `done` rises the cycle after the SCAN in which the DONE condition holds.

## Test plan
- **Single move:** after start, col 3 holds one valid move 0x00A5C. Required: `col_rden`=0x08 for one cycle; `out_valid` with `out_move`=0x00A5C 3 cycles after selection; `move_count`=1; `done` after all `col_done` go high.
- **Round-robin:** cols 0, 2 and 7 each hold 2 moves, `out_ready`=1. Required pop order 0,2,7,0,2,7; `move_count`=6; `done`=1.
- **Invalid filter:** col 5 holds moves 0x40123 (invalid) then 0x01234. Required: only 0x01234 output; `drop_count`=1; `move_count`=1.
- **Backpressure:** `out_ready` held low for 10 cycles while in OUT. Required: `out_move` stable; `col_rden` stays 0; exactly one transfer when `out_ready` rises.
- **Done gating:** all `col_done`=1 but col 6 not empty. Required: `done` stays 0 until col 6 is drained, then `done`=1 the cycle after the final SCAN.
- **Reset mid-op:** `reset_n` asserted while in READ. Required: `col_rden`, `out_valid`, `busy` and the counters read 0 immediately; after release, the state is IDLE and waits for `start`.

Source files
------------

// File: rtl/board_move_collector.sv
// board_move_collector
// Round-robin gatherer over the eight column move FIFOs. Pops one move at a
// time, discards moves flagged invalid, streams the survivors on a single
// valid/ready port and reports done once every column has finished and all
// column FIFOs are drained. All outputs are registered.
module board_move_collector #(
  parameter int NCOL = 8,
  parameter int MW   = 19,
  parameter int CW   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NCOL-1:0]      col_done,
  input  logic [NCOL-1:0]      col_empty,
  input  logic [NCOL*MW-1:0]   col_data,
  output logic [NCOL-1:0]      col_rden,
  output logic [MW-1:0]        out_move,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        move_count,
  output logic [CW-1:0]        drop_count,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = $clog2(NCOL);
  localparam logic [PW-1:0]   PTR_LAST = PW'(NCOL - 1);
  localparam logic [NCOL-1:0] COL_ONE  = NCOL'(1);
  localparam logic [NCOL-1:0] COL_NONE = NCOL'(0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
  localparam logic [MW-1:0]   MOVE_ZERO = MW'(0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_READ = 3'd2,
    ST_CAPT = 3'd3,
    ST_OUT  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Saturating increment: counters stick at their maximum instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
    sat_inc = (value == CNT_MAX) ? value : (value + CNT_ONE);
  endfunction

  state_t          state_r;
  logic [PW-1:0]   rr_ptr_r;
  logic [PW-1:0]   sel_r;

  state_t          next_state_s;
  logic [PW-1:0]   next_rr_ptr_s;
  logic [PW-1:0]   next_sel_s;
  logic [NCOL-1:0] next_rden_s;
  logic [MW-1:0]   next_move_s;
  logic [CW-1:0]   next_move_count_s;
  logic [CW-1:0]   next_drop_count_s;
  logic            next_valid_s;
  logic            next_busy_s;
  logic            next_done_s;

  logic [MW-1:0]   col_words_s [NCOL];
  logic [MW-1:0]   capt_word_s;
  logic            found_s;
  logic            hit_s;
  logic [PW-1:0]   idx_s;
  logic [PW-1:0]   pick_s;

  genvar g;
  for (g = 0; g < NCOL; g++) begin : g_slice
    assign col_words_s[g] = col_data[g*MW +: MW];
  end

  assign capt_word_s = col_words_s[sel_r];

  // Round-robin search: first non-empty column starting just after rr_ptr.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = rr_ptr_r;
    pick_s  = rr_ptr_r;
    for (int i = 1; i <= NCOL; i++) begin
      idx_s   = rr_ptr_r + PW'(i);
      hit_s   = !found_s && !col_empty[idx_s];
      pick_s  = hit_s ? idx_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // Next-state and next-output logic for the collection FSM.
  always_comb begin
    next_state_s      = state_r;
    next_rr_ptr_s     = rr_ptr_r;
    next_sel_s        = sel_r;
    next_rden_s       = COL_NONE;
    next_move_s       = out_move;
    next_move_count_s = move_count;
    next_drop_count_s = drop_count;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_move_count_s = CNT_ZERO;
          next_drop_count_s = CNT_ZERO;
          next_rr_ptr_s     = PTR_LAST;
          next_state_s      = ST_SCAN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (found_s) begin
          next_sel_s    = pick_s;
          next_rr_ptr_s = pick_s;
          next_rden_s   = COL_ONE << pick_s;
          next_state_s  = ST_READ;
        end else if (&col_done) begin
          // Nothing eligible means every FIFO is empty as well.
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SCAN;
        end
      end
      ST_READ: begin
        next_state_s = ST_CAPT;
      end
      ST_CAPT: begin
        if (capt_word_s[MW-1]) begin
          next_drop_count_s = sat_inc(drop_count);
          next_state_s      = ST_SCAN;
        end else begin
          next_move_s  = capt_word_s;
          next_state_s = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          next_move_count_s = sat_inc(move_count);
          next_state_s      = ST_SCAN;
        end else begin
          next_state_s = ST_OUT;
        end
      end
      ST_DONE: begin
        if (start) begin
          next_move_count_s = CNT_ZERO;
          next_drop_count_s = CNT_ZERO;
          next_state_s      = ST_SCAN;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    next_valid_s = (next_state_s == ST_OUT);
    next_done_s  = (next_state_s == ST_DONE);
    next_busy_s  = (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
  end

  // State register and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= PTR_LAST;
      sel_r      <= PW'(0);
      col_rden   <= COL_NONE;
      out_move   <= MOVE_ZERO;
      out_valid  <= 1'b0;
      move_count <= CNT_ZERO;
      drop_count <= CNT_ZERO;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      rr_ptr_r   <= next_rr_ptr_s;
      sel_r      <= next_sel_s;
      col_rden   <= next_rden_s;
      out_move   <= next_move_s;
      out_valid  <= next_valid_s;
      move_count <= next_move_count_s;
      drop_count <= next_drop_count_s;
      busy       <= next_busy_s;
      done       <= next_done_s;
    end
  end

endmodule
